// File: rtl/ex_decode.sv
// ex_decode: recovers P from the encoded product R = P*DIVISOR using a
// bit-serial restoring divider. It also returns Q[4:2] and cross-checks the
// rotated (V) and packed (W) encodings against the quotient.
module ex_decode #(
    parameter int DIVISOR = 3,
    parameter int RW      = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] r_in,
    input  logic [4:0]    v_in,
    input  logic [5:0]    w_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    p_out,
    output logic [2:0]    q_hi,
    output logic          err_rem,
    output logic          err_range,
    output logic          err_rot,
    output logic          err_w,
    output logic          ok
);

    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [RW-1:0] r_lat;
    logic [4:0]    v_lat;
    logic [5:0]    w_lat;
    logic [RW-1:0] quot;
    logic [2:0]    rem;
    logic [CW-1:0] cnt;

    logic [3:0]    rem_shift;
    logic [2:0]    rem_sub;
    logic          rem_ge;
    logic          accept;
    logic          release_out;
    logic          is_done;

    // One restoring-divide step: shift in the next dividend bit, then subtract if it fits
    always_comb begin
        rem_shift = {rem, r_lat[cnt]};
        rem_ge    = (rem_shift >= 4'(DIVISOR));
        rem_sub   = 3'(rem_shift - 4'(DIVISOR));
    end

    assign accept      = (state == IDLE) && in_valid;
    assign release_out = (state == DONE) && out_ready;
    assign is_done     = (state == DONE);

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, iterate RW times in DIV, hold in DONE until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (release_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and divider datapath, MSB of the dividend first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat <= '0;
            v_lat <= '0;
            w_lat <= '0;
            quot  <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            r_lat <= r_in;
            v_lat <= v_in;
            w_lat <= w_in;
            quot  <= '0;
            rem   <= '0;
            cnt   <= CW'(RW - 1);
        end else if (state == DIV) begin
            rem       <= rem_ge ? rem_sub : rem_shift[2:0];
            quot[cnt] <= rem_ge;
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Results and consistency flags are only visible while DONE, zero otherwise
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = is_done;
        p_out     = is_done ? quot[4:0] : 5'd0;
        q_hi      = is_done ? w_lat[2:0] : 3'd0;
        err_rem   = is_done && (rem != 3'd0);
        err_range = is_done && ((quot >> 5) != '0);
        err_rot   = is_done && ({v_lat[2:0], v_lat[4:3]} != quot[4:0]);
        err_w     = is_done && (w_lat[5:3] != quot[2:0]);
        ok        = is_done && !(err_rem || err_range || err_rot || err_w);
    end

endmodule

// File: tb/tb_ex_decode.sv
// tb_ex_decode: directed and random operand sets for ex_decode, compared
// against division/modulo arithmetic computed in the bench.
module tb_ex_decode;

    localparam int DIVISOR = 3;
    localparam int RW      = 7;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] r_in;
    logic [4:0]    v_in;
    logic [5:0]    w_in;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    p_out;
    logic [2:0]    q_hi;
    logic          err_rem;
    logic          err_range;
    logic          err_rot;
    logic          err_w;
    logic          ok;

    int checks   = 0;
    int failures = 0;

    ex_decode #(
        .DIVISOR(DIVISOR),
        .RW     (RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .r_in     (r_in),
        .v_in     (v_in),
        .w_in     (w_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p_out    (p_out),
        .q_hi     (q_hi),
        .err_rem  (err_rem),
        .err_range(err_range),
        .err_rot  (err_rot),
        .err_w    (err_w),
        .ok       (ok)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected results straight from integer division of the encoded product
    task automatic checkModel(input string tag, input int r, input int v, input int w);
        int q;
        int rm;
        int p;
        int rot;
        bit e_rem;
        bit e_range;
        bit e_rot;
        bit e_w;
        q       = r / DIVISOR;
        rm      = r % DIVISOR;
        p       = q % 32;
        rot     = (v % 8) * 4 + (v / 8);
        e_rem   = (rm != 0);
        e_range = (q > 31);
        e_rot   = (rot != p);
        e_w     = ((w / 8) != (q % 8));
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_p_out"}, 32'(p_out), 32'(p));
        checkOutput({tag, "_q_hi"}, 32'(q_hi), 32'(w % 8));
        checkOutput({tag, "_err_rem"}, 32'(err_rem), 32'(e_rem));
        checkOutput({tag, "_err_range"}, 32'(err_range), 32'(e_range));
        checkOutput({tag, "_err_rot"}, 32'(err_rot), 32'(e_rot));
        checkOutput({tag, "_err_w"}, 32'(err_w), 32'(e_w));
        checkOutput({tag, "_ok"}, 32'(ok), 32'(!(e_rem || e_range || e_rot || e_w)));
    endtask

    // Offer one operand set, scramble the inputs after acceptance, wait for DONE, check
    task automatic applyStimulus(input string tag, input int r, input int v, input int w);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        r_in     = 7'(r);
        v_in     = 5'(v);
        w_in     = 6'(w);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        r_in     = 7'($urandom_range(0, 127));
        v_in     = 5'($urandom_range(0, 31));
        w_in     = 6'($urandom_range(0, 63));
        checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(RW));
        checkModel(tag, r, v, w);
    endtask

    // With out_ready high the result is taken on the first DONE edge
    task automatic takeResult(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Directed sequence followed by random operand sets
    initial begin
        int p;
        int qv;
        int r;
        int v;
        int w;
        int lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        r_in      = '0;
        v_in      = '0;
        w_in      = '0;
        #2;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_p_out", 32'(p_out), 32'd0);
        checkOutput("rst_q_hi", 32'(q_hi), 32'd0);
        checkOutput("rst_flags", 32'({err_rem, err_range, err_rot, err_w, ok}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed cases");
        applyStimulus("nominal", 39, 11, 45);
        takeResult("nominal");
        applyStimulus("remainder", 40, 11, 45);
        takeResult("remainder");
        applyStimulus("range", 99, 0, 0);
        takeResult("range");
        applyStimulus("zero", 0, 0, 0);
        takeResult("zero");
        applyStimulus("max", 127, 0, 0);
        takeResult("max");

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus("bp_first", 39, 11, 45);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            r_in     = 7'd99;
            v_in     = 5'd0;
            w_in     = 6'd0;
            @(posedge clk);
            #1;
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_p_out", 32'(p_out), 32'd13);
            checkOutput("bp_hold_q_hi", 32'(q_hi), 32'd5);
            checkOutput("bp_hold_ok", 32'(ok), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_second_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("bp_second_latency", 32'(lat), 32'(RW));
        checkModel("bp_second", 99, 0, 0);
        takeResult("bp_second");

        $display("[TB] reset mid-operation");
        @(negedge clk);
        in_valid = 1'b1;
        r_in     = 7'd127;
        v_in     = 5'd31;
        w_in     = 6'd63;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_p_out", 32'(p_out), 32'd0);
        checkOutput("midrst_flags", 32'({err_rem, err_range, err_rot, err_w, ok}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post_reset", 39, 11, 45);
        takeResult("post_reset");

        $display("[TB] random cases");
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) begin
                p = int'($urandom_range(0, 31));
                qv = int'($urandom_range(0, 31));
                r = p * DIVISOR;
                v = (p % 4) * 8 + (p / 4);
                w = (p % 8) * 8 + (qv / 4);
            end else begin
                r = int'($urandom_range(0, 127));
                v = int'($urandom_range(0, 31));
                w = int'($urandom_range(0, 63));
            end
            applyStimulus("random", r, v, w);
            takeResult("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
